// File: rtl/video_pkg.sv
// Shared OAM DMA definitions: controller state encoding and transfer length.
package video_pkg;

  localparam int OAM_DMA_BYTES = 256;
  localparam logic [7:0] OAM_LAST_BYTE = 8'(OAM_DMA_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HALT   = 3'd1,
    GET    = 3'd2,
    PUT    = 3'd3,
`ifdef VIDEO_OAM_DMA_ALIGN_EN
    FINISH = 3'd4,
    ALIGN  = 3'd5
`else
    FINISH = 3'd4
`endif
  } dma_state_t;

endpackage

// File: rtl/video_oam_dma.sv
// $4014 sprite DMA: halts the CPU, copies page {page,00..FF} into OAM and arbitrates $2003/$2004 CPU writes.
// VIDEO_OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state (515-cycle DMA); without it every DMA is 514 cycles.
module video_oam_dma
  import video_pkg::*;
(
  input  logic        I_clock,
  input  logic        I_reset,
  input  logic        I_dma_start,
  input  logic [7:0]  I_dma_page,
  input  logic        I_cycle_odd,
  input  logic        I_cpu_addr_wren,
  input  logic        I_cpu_data_wren,
  input  logic [7:0]  I_cpu_data,
  input  logic [7:0]  I_bus_data,
  output logic        O_halt,
  output logic        O_busy,
  output logic [15:0] O_bus_addr,
  output logic        O_bus_rden,
  output logic        O_oam_addr_wren,
  output logic        O_oam_addr_inc,
  output logic        O_oam_data_wren,
  output logic [7:0]  O_oam_data,
  output logic        O_cpu_drop
);

  dma_state_t r_state;
  dma_state_t w_next;
  logic [7:0] r_cnt;
  logic [7:0] r_page;
  logic [7:0] r_data;
  logic       r_inc_pending;
  logic       w_cpu_ok;
  logic       w_addr_wr;
  logic       w_data_wr;

`ifndef VIDEO_OAM_DMA_ALIGN_EN
  logic w_unused_cycle_odd;
  assign w_unused_cycle_odd = I_cycle_odd;
`endif

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_state       <= IDLE;
      r_cnt         <= 8'h00;
      r_page        <= 8'h00;
      r_data        <= 8'h00;
      r_inc_pending <= 1'b0;
    end else begin
      r_state       <= w_next;
      // A serviced $2004 write owes exactly one address increment on the following cycle.
      r_inc_pending <= w_data_wr;
      if (r_state == IDLE && I_dma_start) begin
        r_page <= I_dma_page;
        r_cnt  <= 8'h00;
      end
      if (r_state == GET) begin
        r_data <= I_bus_data;
      end
      if (r_state == PUT && r_cnt != OAM_LAST_BYTE) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    w_next          = r_state;
    // The CPU still completes its write during the HALT cycle; later ones are lost.
    w_cpu_ok        = (r_state == IDLE) || (r_state == HALT);
    w_addr_wr       = w_cpu_ok && I_cpu_addr_wren;
    w_data_wr       = w_cpu_ok && I_cpu_data_wren && !I_cpu_addr_wren && !r_inc_pending;
    O_halt          = (r_state != IDLE);
    O_busy          = (r_state != IDLE);
    O_bus_addr      = 16'h0000;
    O_bus_rden      = 1'b0;
    O_oam_addr_wren = w_addr_wr;
    O_oam_data_wren = w_data_wr;
    O_oam_addr_inc  = r_inc_pending && !w_addr_wr;
    O_oam_data      = (w_addr_wr || w_data_wr) ? I_cpu_data : 8'h00;
    O_cpu_drop      = w_cpu_ok ? (I_cpu_data_wren && (I_cpu_addr_wren || r_inc_pending))
                               : (I_cpu_addr_wren || I_cpu_data_wren);

    case (r_state)
      IDLE: begin
        if (I_dma_start) w_next = HALT;
      end
      HALT: begin
`ifdef VIDEO_OAM_DMA_ALIGN_EN
        w_next = I_cycle_odd ? ALIGN : GET;
`else
        w_next = GET;
`endif
      end
`ifdef VIDEO_OAM_DMA_ALIGN_EN
      ALIGN: begin
        w_next = GET;
      end
`endif
      GET: begin
        O_bus_rden     = 1'b1;
        O_bus_addr     = {r_page, r_cnt};
        // Advance past the byte written in the previous PUT; byte 0 needs no step.
        O_oam_addr_inc = O_oam_addr_inc || (r_cnt != 8'h00);
        w_next         = PUT;
      end
      PUT: begin
        O_oam_data_wren = 1'b1;
        O_oam_data      = r_data;
        w_next          = (r_cnt == OAM_LAST_BYTE) ? FINISH : GET;
      end
      FINISH: begin
        O_oam_addr_inc = 1'b1;
        w_next         = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase

    if (!I_reset) begin
      O_halt          = 1'b0;
      O_busy          = 1'b0;
      O_bus_addr      = 16'h0000;
      O_bus_rden      = 1'b0;
      O_oam_addr_wren = 1'b0;
      O_oam_addr_inc  = 1'b0;
      O_oam_data_wren = 1'b0;
      O_oam_data      = 8'h00;
      O_cpu_drop      = 1'b0;
    end
  end

endmodule

// File: doc/video_oam_dma.md
VIDEO_OAM_DMA -- requirements
Module: video_oam_dma

Interface
REQ-001 SHALL have ports: I_clock  in  1  clock; I_reset  in  1  async reset, active-low.
REQ-002 SHALL have I_dma_start  in  1  strobe, CPU write to $4014 (one cycle).
REQ-003 SHALL have I_dma_page  in  8  source page; sampled with I_dma_start.
REQ-004 SHALL have I_cycle_odd  in  1  high when the current CPU cycle is odd (alignment).
REQ-005 SHALL have I_cpu_addr_wren, I_cpu_data_wren  in  1 each  CPU writes to $2003/$2004.
REQ-006 SHALL have I_cpu_data  in  8  CPU write data.
REQ-007 SHALL have I_bus_data  in  8  CPU-bus read data for DMA GET.
REQ-008 SHALL have O_halt  out  1  CPU halt (RDY low); O_busy  out  1  DMA in progress.
REQ-009 SHALL have O_bus_addr  out  16  DMA read address; O_bus_rden  out  1  DMA read strobe.
REQ-010 SHALL have O_oam_addr_wren, O_oam_addr_inc, O_oam_data_wren  out  1 each; O_oam_data  out  8  to the OAM store.
REQ-011 SHALL have O_cpu_drop  out  1  pulse when a CPU OAM write is discarded.

Function
REQ-012 FSM states: IDLE, HALT, ALIGN, GET, PUT, FINISH; 8-bit byte counter cnt.
REQ-013 IDLE + I_dma_start -> HALT next cycle; page latched; cnt=0. Start outside IDLE ignored.
REQ-014 HALT -> ALIGN if I_cycle_odd sampled in HALT, else GET. ALIGN -> GET. Both take exactly one cycle.
REQ-015 GET: O_bus_rden=1, O_bus_addr={page,cnt}; I_bus_data captured at cycle end into data reg; -> PUT.
REQ-016 PUT: O_oam_data_wren=1, O_oam_data=data reg; cnt==255 -> FINISH, else cnt+1 and -> GET.
REQ-017 O_oam_addr_inc=1 in every GET with cnt!=0 and in FINISH; never asserted in the same cycle as O_oam_data_wren.
REQ-018 FINISH -> IDLE; total DMA = 514 cycles (even start) / 515 (odd start); OAM address ends at its pre-DMA value (wrap by 256).
REQ-019 O_halt=O_busy=1 in all states except IDLE; combinational from state.
REQ-020 IDLE, CPU path: I_cpu_addr_wren -> O_oam_addr_wren=1, O_oam_data=I_cpu_data, same cycle; clears pending inc.
REQ-021 IDLE, I_cpu_data_wren -> O_oam_data_wren=1, O_oam_data=I_cpu_data, same cycle; sets inc_pending.
REQ-022 inc_pending -> O_oam_addr_inc=1 next cycle (also in HALT), then cleared.
REQ-023 CPU data write while inc_pending: inc issued, write discarded, O_cpu_drop=1 that cycle.
REQ-024 CPU writes outside IDLE/HALT are discarded with O_cpu_drop=1; addr_wren and data_wren together: addr_wren wins, data write dropped.
REQ-025 Start and CPU write in the same IDLE cycle: CPU write serviced, DMA begins next cycle.
REQ-026 O_bus_addr=0 and O_oam_data=0 when not driven by GET/PUT/CPU path.

Reset
REQ-027 I_reset low: state IDLE, cnt=0, page=0, data reg=0, inc_pending=0; all outputs 0 immediately, including mid-DMA.
REQ-028 No OAM strobe SHALL be asserted in the first cycle after reset release unless a CPU write arrives.

Configuration
REQ-029 VIDEO_OAM_DMA_ALIGN_EN defined: ALIGN state per REQ-014.
REQ-030 VIDEO_OAM_DMA_ALIGN_EN undefined: I_cycle_odd ignored, ALIGN removed, HALT -> GET always, DMA = 514 cycles.

Structure
REQ-031 State enum and constant OAM_DMA_BYTES=256 SHALL live in package video_pkg.
REQ-032 Single module, no sub-modules; the OAM store stays a separate instance driven by this block's outputs.

Verification
REQ-033 Page 0x02, even start, bus returns low address byte -> O_halt high 514 cycles, reads 0x0200..0x02FF, OAM[i]=i, addr back to start.
REQ-034 Page 0x07, odd start (ALIGN_EN) -> 515 halt cycles, first GET 2 cycles after HALT; without macro -> 514.
REQ-035 Idle: $2003 write 0x10, $2004 write 0xAB -> OAM[0x10]=0xAB, address 0x11 one cycle later.
REQ-036 $2004 writes on two consecutive cycles -> second dropped, O_cpu_drop pulse, address +1 only.
REQ-037 Reset asserted at cnt=100 -> O_halt low immediately; restart page 0x03 -> full 514-cycle DMA.
REQ-038 I_dma_start re-pulsed during DMA -> ignored, transfer count stays 256.
